// File: rtl/instr_decoder.sv
// instr_decoder -- instruction decoder for the 8-bit microprocessor.
//
// Decodes the program-memory word for the current pc into sequencer jump
// controls and computational-unit load enables / selects. It also holds the
// zero flag, which is exported as dont_jmp, and a registered copy of the
// last executed instruction.
//
// Ports:
//   i_clk         system clock, all state on rising edge
//   i_sync_reset  synchronous active-high reset
//   i_pm_data     instruction word for current pc
//   i_alu_zero    combinational "ALU result == 0" for current instruction
//   o_jmp         unconditional jump (combinational)
//   o_jmp_nz      jump-if-not-zero request (combinational)
//   o_jmp_addr    jump target nibble = pm_data[3:0]
//   o_dont_jmp    registered zero flag
//   o_ld_en       one-hot load enables indexed by dst code
//   o_r_en        load r from ALU
//   o_imm         immediate = pm_data[3:0]
//   o_data_sel    1 = immediate onto bus, 0 = source register
//   o_src_sel     source register code
//   o_x_sel       ALU x operand select
//   o_y_sel       ALU y operand select
//   o_alu_func    ALU function
//   o_i_inc       post-increment i by m (dm accessed)
//   o_ir          registered copy of last executed instruction
//   o_instr_cnt   retired-instruction count
//
// Build option: define INSTR_CNT_EN to build the retired-instruction counter;
// otherwise o_instr_cnt is tied to zero. Port list is the same either way.

module instr_decoder (
  input  logic        i_clk,
  input  logic        i_sync_reset,
  input  logic [7:0]  i_pm_data,
  input  logic        i_alu_zero,
  output logic        o_jmp,
  output logic        o_jmp_nz,
  output logic [3:0]  o_jmp_addr,
  output logic        o_dont_jmp,
  output logic [7:0]  o_ld_en,
  output logic        o_r_en,
  output logic [3:0]  o_imm,
  output logic        o_data_sel,
  output logic [2:0]  o_src_sel,
  output logic        o_x_sel,
  output logic        o_y_sel,
  output logic [2:0]  o_alu_func,
  output logic        o_i_inc,
  output logic [7:0]  o_ir,
  output logic [15:0] o_instr_cnt
);

  logic [2:0] w_dst;
  logic [2:0] w_src;
  logic       w_is_alu;
  logic       w_jmp;
  logic       w_jmp_nz;
  logic [7:0] w_ld_en;
  logic       w_r_en;
  logic       w_data_sel;
  logic [2:0] w_src_sel;
  logic       w_x_sel;
  logic       w_y_sel;
  logic [2:0] w_alu_func;
  logic       w_i_inc;

  logic       r_flag;
  logic [7:0] r_ir;

  assign w_dst = i_pm_data[5:3];
  assign w_src = i_pm_data[2:0];

  always_comb begin
    w_is_alu   = 1'b0;
    w_jmp      = 1'b0;
    w_jmp_nz   = 1'b0;
    w_ld_en    = 8'h00;
    w_r_en     = 1'b0;
    w_data_sel = 1'b0;
    w_src_sel  = 3'd0;
    w_x_sel    = 1'b0;
    w_y_sel    = 1'b0;
    w_alu_func = 3'd0;
    w_i_inc    = 1'b0;

    casez (i_pm_data[7:4])
      4'b0???: begin // LOAD: dst is bits [6:4]
        w_ld_en    = 8'h01 << i_pm_data[6:4];
        w_data_sel = 1'b1;
        w_i_inc    = (i_pm_data[6:4] == 3'd7);
      end
      4'b10??: begin // MOV; dst == src is a NOP with no side effects
        w_src_sel = w_src;
        if (w_dst != w_src) begin
          w_ld_en = 8'h01 << w_dst;
          w_i_inc = (w_dst == 3'd7) || (w_src == 3'd7);
        end
      end
      4'b110?: begin // ALU
        w_is_alu   = 1'b1;
        w_r_en     = 1'b1;
        w_x_sel    = i_pm_data[4];
        w_y_sel    = i_pm_data[3];
        w_alu_func = i_pm_data[2:0];
      end
      4'b1110: w_jmp    = 1'b1;
      default: w_jmp_nz = 1'b1; // 1111 JNZ
    endcase

    // Reset must dominate immediately, before the reset edge arrives.
    if (i_sync_reset) begin
      w_jmp      = 1'b0;
      w_jmp_nz   = 1'b0;
      w_ld_en    = 8'h00;
      w_r_en     = 1'b0;
      w_i_inc    = 1'b0;
      w_data_sel = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_flag <= 1'b0;
      r_ir   <= 8'h00;
    end else begin
      r_ir <= i_pm_data;
      if (w_is_alu)
        r_flag <= i_alu_zero;
    end
  end

`ifdef INSTR_CNT_EN
  logic [15:0] r_instr_cnt;

  // Counts every unreset edge, NOPs included; wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_sync_reset)
      r_instr_cnt <= 16'h0000;
    else
      r_instr_cnt <= r_instr_cnt + 16'h0001;
  end

  assign o_instr_cnt = r_instr_cnt;
`else
  assign o_instr_cnt = 16'h0000;
`endif

  assign o_jmp      = w_jmp;
  assign o_jmp_nz   = w_jmp_nz;
  assign o_jmp_addr = i_pm_data[3:0];
  assign o_imm      = i_pm_data[3:0];
  assign o_dont_jmp = r_flag;
  assign o_ld_en    = w_ld_en;
  assign o_r_en     = w_r_en;
  assign o_data_sel = w_data_sel;
  assign o_src_sel  = w_src_sel;
  assign o_x_sel    = w_x_sel;
  assign o_y_sel    = w_y_sel;
  assign o_alu_func = w_alu_func;
  assign o_i_inc    = w_i_inc;
  assign o_ir       = r_ir;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: the driver applies one instruction per
// cycle (after the rising edge) and queues hand-computed expectations; the
// monitor pops and compares on the falling edge of every checked cycle.
// Registered fields (dont_jmp, ir, instr_cnt) reflect edges up to the one
// that started the current cycle.

module tb_instr_decoder;

  logic        clk;
  logic        sync_reset;
  logic [7:0]  pm_data;
  logic        alu_zero;
  logic        jmp, jmp_nz, dont_jmp, r_en, data_sel, x_sel, y_sel, i_inc;
  logic [3:0]  jmp_addr, imm;
  logic [7:0]  ld_en, ir;
  logic [2:0]  src_sel, alu_func;
  logic [15:0] instr_cnt;

  instr_decoder dut (
    .i_clk        (clk),
    .i_sync_reset (sync_reset),
    .i_pm_data    (pm_data),
    .i_alu_zero   (alu_zero),
    .o_jmp        (jmp),
    .o_jmp_nz     (jmp_nz),
    .o_jmp_addr   (jmp_addr),
    .o_dont_jmp   (dont_jmp),
    .o_ld_en      (ld_en),
    .o_r_en       (r_en),
    .o_imm        (imm),
    .o_data_sel   (data_sel),
    .o_src_sel    (src_sel),
    .o_x_sel      (x_sel),
    .o_y_sel      (y_sel),
    .o_alu_func   (alu_func),
    .o_i_inc      (i_inc),
    .o_ir         (ir),
    .o_instr_cnt  (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  ld_en;
    logic        data_sel;
    logic [2:0]  src_sel;
    logic        r_en;
    logic        x_sel;
    logic        y_sel;
    logic [2:0]  alu_func;
    logic        jmp;
    logic        jmp_nz;
    logic        i_inc;
    logic [3:0]  nib;
    logic        dont_jmp;
    logic [7:0]  ir;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  bit   req;
  int   tests;
  int   fails;

  function automatic exp_t mk(input logic [7:0] id, input logic [7:0] le,
      input logic ds, input logic [2:0] ss, input logic re, input logic xs,
      input logic ys, input logic [2:0] fn, input logic jp, input logic jn,
      input logic ii, input logic [3:0] nb, input logic dj,
      input logic [7:0] irv, input logic [15:0] cnt);
    exp_t e;
    e.id = id; e.ld_en = le; e.data_sel = ds; e.src_sel = ss; e.r_en = re;
    e.x_sel = xs; e.y_sel = ys; e.alu_func = fn; e.jmp = jp; e.jmp_nz = jn;
    e.i_inc = ii; e.nib = nb; e.dont_jmp = dj; e.ir = irv;
`ifdef INSTR_CNT_EN
    e.cnt = cnt;
`else
    e.cnt = 16'h0000 & cnt;
`endif
    return e;
  endfunction

  task automatic step(input logic rst, input logic [7:0] pm, input logic az,
                      input bit chk, input exp_t e);
    @(posedge clk);
    #1;
    sync_reset = rst;
    pm_data    = pm;
    alu_zero   = az;
    if (chk) begin
      q.push_back(e);
      req = 1'b1;
    end else begin
      req = 1'b0;
    end
  endtask

  task automatic cmp(input logic [7:0] id, input string nm,
                     input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (req) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp(e.id, "ld_en",     16'(ld_en),     16'(e.ld_en));
        cmp(e.id, "data_sel",  16'(data_sel),  16'(e.data_sel));
        cmp(e.id, "src_sel",   16'(src_sel),   16'(e.src_sel));
        cmp(e.id, "r_en",      16'(r_en),      16'(e.r_en));
        cmp(e.id, "x_sel",     16'(x_sel),     16'(e.x_sel));
        cmp(e.id, "y_sel",     16'(y_sel),     16'(e.y_sel));
        cmp(e.id, "alu_func",  16'(alu_func),  16'(e.alu_func));
        cmp(e.id, "jmp",       16'(jmp),       16'(e.jmp));
        cmp(e.id, "jmp_nz",    16'(jmp_nz),    16'(e.jmp_nz));
        cmp(e.id, "i_inc",     16'(i_inc),     16'(e.i_inc));
        cmp(e.id, "jmp_addr",  16'(jmp_addr),  16'(e.nib));
        cmp(e.id, "imm",       16'(imm),       16'(e.nib));
        cmp(e.id, "dont_jmp",  16'(dont_jmp),  16'(e.dont_jmp));
        cmp(e.id, "ir",        16'(ir),        16'(e.ir));
        cmp(e.id, "instr_cnt", instr_cnt,      e.cnt);
      end
    end
  end

  initial begin
    exp_t nx;
    nx = '0;
    req = 1'b0; tests = 0; fails = 0;
    sync_reset = 1'b1; pm_data = 8'h00; alu_zero = 1'b0;

    //            rst  pm     az chk  id  ld_en ds ss  re x  y  fn  jp jn ii nib  dj ir     cnt
    step(1'b1, 8'hE5, 1'b0, 1, mk( 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h5, 0, 8'h00, 16'd0));
    step(1'b0, 8'h37, 1'b0, 1, mk( 2, 8'h08, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h7, 0, 8'h00, 16'd0));
    step(1'b0, 8'h87, 1'b0, 1, mk( 3, 8'h01, 0, 7, 0, 0, 0, 0, 0, 0, 1, 4'h7, 0, 8'h37, 16'd1));
    step(1'b0, 8'h9B, 1'b0, 1, mk( 4, 8'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4'hB, 0, 8'h87, 16'd2));
    step(1'b0, 8'hC1, 1'b1, 1, mk( 5, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4'h1, 0, 8'h9B, 16'd3));
    step(1'b0, 8'hF4, 1'b0, 1, mk( 6, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h4, 1, 8'hC1, 16'd4));
    step(1'b0, 8'hC1, 1'b0, 1, mk( 7, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4'h1, 1, 8'hF4, 16'd5));
    step(1'b0, 8'hF4, 1'b1, 1, mk( 8, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h4, 0, 8'hC1, 16'd6));
    step(1'b0, 8'hD8, 1'b1, 1, mk( 9, 8'h00, 0, 0, 1, 1, 1, 0, 0, 0, 0, 4'h8, 0, 8'hF4, 16'd7));
    step(1'b0, 8'hE3, 1'b0, 1, mk(10, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'h3, 1, 8'hD8, 16'd8));
    step(1'b0, 8'h7F, 1'b0, 1, mk(11, 8'h80, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 1, 8'hE3, 16'd9));
    step(1'b0, 8'hBF, 1'b0, 1, mk(12, 8'h00, 0, 7, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 8'h7F, 16'd10));
    // Reset mid-program on an ALU instruction: enables forced off, flag cleared.
    step(1'b1, 8'hC1, 1'b0, 1, mk(13, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h1, 1, 8'hBF, 16'd11));
    step(1'b0, 8'hF4, 1'b0, 1, mk(14, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h4, 0, 8'h00, 16'd0));
    step(1'b0, 8'hA7, 1'b0, 1, mk(15, 8'h10, 0, 7, 0, 0, 0, 0, 0, 0, 1, 4'h7, 0, 8'hF4, 16'd1));
    step(1'b0, 8'hB8, 1'b0, 1, mk(16, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h8, 0, 8'hA7, 16'd2));
    step(1'b1, 8'h37, 1'b1, 1, mk(17, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h7, 0, 8'hB8, 16'd3));

`ifdef INSTR_CNT_EN
    for (int i = 0; i < 65535; i++)
      step(1'b0, 8'h9B, 1'b0, 0, nx);
    step(1'b0, 8'h9B, 1'b0, 1, mk(18, 8'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4'hB, 0, 8'h9B, 16'hFFFF));
    step(1'b0, 8'h9B, 1'b0, 1, mk(19, 8'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4'hB, 0, 8'h9B, 16'h0000));
    step(1'b1, 8'h9B, 1'b0, 0, nx);
    step(1'b0, 8'h9B, 1'b0, 1, mk(20, 8'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4'hB, 0, 8'h00, 16'h0000));
`else
    step(1'b0, 8'h9B, 1'b0, 1, mk(18, 8'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4'hB, 0, 8'h00, 16'h0000));
    for (int i = 0; i < 20; i++)
      step(1'b0, 8'h9B, 1'b0, 0, nx);
    step(1'b0, 8'h9B, 1'b0, 1, mk(19, 8'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4'hB, 0, 8'h9B, 16'h0000));
`endif

    step(1'b0, 8'h00, 1'b0, 0, nx);
    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Instruction decoder for the 8-bit microprocessor. It takes the instruction word `pm_data` that program memory returns for the current `pc` and drives the program sequencer's jump inputs (`jmp`, `jmp_nz`, `jmp_addr`, `dont_jmp`). It also produces the computational unit's load enables and source/ALU selects. The zero flag and a registered instruction copy are held here, so `dont_jmp` is a registered output of this block.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge
- `sync_reset`  in  1  synchronous, active-high reset
- `pm_data`  in  8  instruction word for current `pc`
- `alu_zero`  in  1  computational-unit combinational "ALU result == 0" for current instruction
- `jmp`  out  1  unconditional jump (combinational)
- `jmp_nz`  out  1  jump-if-not-zero request (combinational)
- `jmp_addr`  out  4  jump target nibble, `pm_data[3:0]`
- `dont_jmp`  out  1  registered zero flag
- `ld_en`  out  8  one-hot load enables, index = dst code: 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm
- `r_en`  out  1  load r from ALU
- `imm`  out  4  immediate, `pm_data[3:0]`
- `data_sel`  out  1  1 = immediate onto bus, 0 = source register
- `src_sel`  out  3  source code: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm
- `x_sel` / `y_sel`  out  1 each  ALU operand selects
- `alu_func`  out  3  ALU function
- `i_inc`  out  1  post-increment i by m (dm accessed)
- `ir`  out  8  registered copy of last executed instruction
- `instr_cnt`  out  16  retired-instruction count (see Configuration)

## Operation
- Instruction classes are decoded from `pm_data`:
  - `0ddd_nnnn` LOAD: `ld_en[ddd]=1`, `data_sel=1`, `imm=nnnn`.
  - `10dd_dsss` MOV: `ld_en[ddd]=1`, `data_sel=0`, `src_sel=sss`. If `ddd==sss`, the instruction is a NOP: all enables are 0.
  - `110x_sfff` ALU: `r_en=1`, `x_sel=x`, `y_sel=s`, `alu_func=fff`.
  - `1110_aaaa` JMP: `jmp=1`, `jmp_addr=aaaa`.
  - `1111_aaaa` JNZ: `jmp_nz=1`, `jmp_addr=aaaa`. The sequencer combines this with `dont_jmp`.
- `i_inc=1` when a LOAD or MOV has dst==7, or a MOV has src==7. A NOP MOV 7→7 gives `i_inc=0`.
- Outputs not named for a class are 0. `imm` and `jmp_addr` always equal `pm_data[3:0]`; consumers qualify them by the enables.
- Zero flag: updated only on ALU instructions, `flag <= alu_zero`. All other classes hold it. `dont_jmp = flag`.
- `ir <= pm_data` every non-reset cycle.

## Timing
- Decode outputs are combinational from `pm_data`, with zero latency, so the sequencer forms `pm_addr` in the same cycle.
- The zero flag has 1-cycle latency: an ALU instruction at cycle n affects a JNZ at cycle n+1 or later.
- An ALU instruction followed directly by JNZ is legal. The JNZ sees the flag written at the preceding edge.
- While `sync_reset=1`, the following are forced to 0 combinationally regardless of `pm_data`:
  - `jmp`, `jmp_nz`, `ld_en`, `r_en`, `i_inc`, `data_sel`.
- At a reset edge: flag←0, `ir`←0x00, `instr_cnt`←0.
- Reset asserted mid-program takes effect immediately. No pending flag update survives, even if the cycle holds an ALU instruction.
- The first cycle after reset releases executes `pm_data` normally (instruction 0).

## Configuration
- `INSTR_CNT_EN` defined: `instr_cnt` increments by 1 on every clock edge with `sync_reset=0`, NOPs included, and wraps 0xFFFF→0x0000.
- `INSTR_CNT_EN` undefined: no counter is built, and `instr_cnt` is tied to 16'h0000. The port list is identical in both builds.

## Test plan
- Reset dominance: `sync_reset=1`, `pm_data=8'hE5` → `jmp=0`, `ld_en=0`. After the edge, `dont_jmp=0`, `ir=8'h00`.
- LOAD: `pm_data=8'h37` → `ld_en=8'h08`, `data_sel=1`, `imm=4'h7`, `i_inc=0`, `jmp=0`.
- MOV and NOP:
  - `8'h87` (dm→x0) → `ld_en=8'h01`, `src_sel=7`, `data_sel=0`, `i_inc=1`.
  - `8'h9B` (y1→y1) → all enables 0, `i_inc=0`.
- Flag / JNZ:
  - `8'hC1` with `alu_zero=1` → `r_en=1`, `x_sel=0`, `y_sel=0`, `alu_func=1`.
  - Next cycle `8'hF4` → `jmp_nz=1`, `jmp_addr=4`, `dont_jmp=1`.
  - Repeat with `alu_zero=0` → `dont_jmp=0`.
  - Then `8'hE3` → `jmp=1`, `jmp_addr=3`, flag unchanged.
- Counter (`INSTR_CNT_EN` defined): 65535 unreset cycles → `instr_cnt=16'hFFFF`; one more → `16'h0000`; `sync_reset` pulse → 0. Without the macro, `instr_cnt` stays 0.
